vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator: the successor of the fixed 640x480 controller used by the game display. It produces pixel/line counters, sync pulses of configurable polarity, data-enable, and frame/line strobes. A configurable delay line keeps sync and enable aligned with a multi-stage pixel renderer. Counting advances on a pixel clock-enable, so the block runs either from a divided clock or from the system clock with a strobe.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted sync level (0 = active-low)
- CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, frame counter width
- PIPE_DELAY, 0, renderer latency in enabled cycles (0..8)

Ports:
- pclk  in  1  pixel clock
- reset  in  1  reset, asynchronous, active-high
- ce  in  1  pixel enable; counters and delay line advance only when 1
- h_cnt  out  CNT_W  current pixel, 0..H_TOTAL-1
- v_cnt  out  CNT_W  current line, 0..V_TOTAL-1
- active  out  1  h_cnt < H_ACTIVE and v_cnt < V_ACTIVE (undelayed)
- sol  out  1  start of line: h_cnt==0, registered with counters
- sof  out  1  start of frame: h_cnt==0 and v_cnt==0
- frame_cnt  out  FRAME_W  completed-frame count, wraps
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- de  out  1  delayed data-enable (active delayed by PIPE_DELAY)

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is formed the same way. Every width parameter is at least 1.
- When ce=1: h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. At v_cnt=V_TOTAL-1 with that wrap, v_cnt wraps to 0 and frame_cnt increments, modulo 2^FRAME_W.
- When ce=0, all registers hold, including the delay line.
- Raw sync is asserted when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC. Raw vsync uses v_cnt with the vertical constants. Asserted level comes from *_POL; the idle level is its inverse.
- Raw sync, active, sol and sof are registered and computed from the next counter values. They are therefore exact functions of the h_cnt/v_cnt presented in the same cycle, with no one-cycle skew.
- hsync, vsync and de are the raw signals passed through a PIPE_DELAY-deep shift register clocked on ce. With PIPE_DELAY=0 they equal the raw registered values.
- Comparisons are unsigned, at CNT_W width.

## Timing
- Reset (async) values: h_cnt=0, v_cnt=0, frame_cnt=0, active=1, sol=1, sof=1. hsync and vsync sit at the idle level, and every delay-line stage is filled with idle sync and de=0. de=0 after reset.
- Reset asserted mid-frame: all outputs take their reset values immediately. The first ce after release moves to h_cnt=1.
- Counter latency: a change is visible one pclk after an enabled edge.
- hsync, vsync and de lag the raw signals by exactly PIPE_DELAY enabled cycles. Disabled cycles do not count toward this lag.
- Simultaneous line wrap and frame wrap happen in the same cycle. sof and sol are both 1 when (0,0) is presented.
- frame_cnt wraps from 2^FRAME_W-1 to 0 with no status flag.

## Structure
- Shared package vga_pkg:
  - 640x480@60 timing constants.
  - Sync polarity constants.
  - A timing-parameter struct typedef used by renderers for bounds checks.
- Sub-module vga_sync_delay: parametrised depth-N, width-3 shift register with enable. Depth 0 degenerates to a wire.

## Test plan
Test parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), PIPE_DELAY=0 unless stated.
- Reset then ce=1 continuously:
  - h_cnt counts 0..13 and wraps.
  - hsync is low (active-low) exactly at h_cnt 10..11.
  - active=1 for h_cnt 0..7 on lines 0..3.
- One full frame of 98 enabled cycles:
  - vsync is low only on v_cnt=5.
  - frame_cnt goes 0->1 when sof reappears.
  - sof pulses once per 98 cycles.
- ce toggling 1,0,1,0:
  - counters advance once per two clocks.
  - all outputs are stable during ce=0 cycles.
- PIPE_DELAY=3:
  - de rises 3 enabled cycles after active.
  - hsync falls 3 enabled cycles after raw h_cnt=10.
  - after reset, de=0 and hsync is idle for the first 3 enabled cycles.
- HSYNC_POL=1, VSYNC_POL=1: both pulses invert; reset level is 0.
- reset asserted at h_cnt=9, v_cnt=2:
  - all outputs return to reset values without a clock edge.
  - counting resumes from (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the timing descriptor used by renderers.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam bit SYNC_ACT_LOW  = 1'b0;
    localparam bit SYNC_ACT_HIGH = 1'b1;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_front;
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] v_active;
        logic [15:0] v_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
        logic        hsync_pol;
        logic        vsync_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_active:  16'(VGA_H_ACTIVE),
        h_front:   16'(VGA_H_FRONT),
        h_sync:    16'(VGA_H_SYNC),
        h_back:    16'(VGA_H_BACK),
        v_active:  16'(VGA_V_ACTIVE),
        v_front:   16'(VGA_V_FRONT),
        v_sync:    16'(VGA_V_SYNC),
        v_back:    16'(VGA_V_BACK),
        hsync_pol: SYNC_ACT_LOW,
        vsync_pol: SYNC_ACT_LOW
    };

    function automatic logic [15:0] h_total(input vga_timing_t t);
        return t.h_active + t.h_front + t.h_sync + t.h_back;
    endfunction

    function automatic logic [15:0] v_total(input vga_timing_t t);
        return t.v_active + t.v_front + t.v_sync + t.v_back;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register aligning {de, vsync, hsync} with renderer latency.
module vga_sync_delay #(
    parameter int         DEPTH   = 0,
    parameter logic [2:0] RST_VAL = 3'b011
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       ce,
    input  logic [2:0] d,
    output logic [2:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{pclk, reset, ce};
        assign q = d;
    end else begin : g_pipe
        logic [2:0] sr [DEPTH];

        always_ff @(posedge pclk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
            end else if (ce) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel enable and
// a renderer-latency delay line on sync and data-enable.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter bit HSYNC_POL  = SYNC_ACT_LOW,
    parameter bit VSYNC_POL  = SYNC_ACT_LOW,
    parameter int CNT_W      = 11,
    parameter int FRAME_W    = 8,
    parameter int PIPE_DELAY = 0
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               ce,
    output logic [CNT_W-1:0]   h_cnt,
    output logic [CNT_W-1:0]   v_cnt,
    output logic               active,
    output logic               sol,
    output logic               sof,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               hsync,
    output logic               vsync,
    output logic               de
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             act_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             hs_raw;
    logic             vs_raw;
    logic             de_raw;

    always_comb begin
        h_wrap  = (h_cnt == H_LAST);
        v_wrap  = (v_cnt == V_LAST);
        h_nxt   = h_wrap ? '0 : h_cnt + CNT_W'(1);
        v_nxt   = v_cnt;
        if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + CNT_W'(1);
        act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt  = (h_nxt >= HS_ON && h_nxt < HS_OFF) ? HSYNC_POL : ~HSYNC_POL;
        vs_nxt  = (v_nxt >= VS_ON && v_nxt < VS_OFF) ? VSYNC_POL : ~VSYNC_POL;
    end

    // Raw strobes are computed from next counts so they line up with h_cnt/v_cnt.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            active    <= 1'b1;
            sol       <= 1'b1;
            sof       <= 1'b1;
            hs_raw    <= ~HSYNC_POL;
            vs_raw    <= ~VSYNC_POL;
            de_raw    <= 1'b0;
        end else if (ce) begin
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            if (h_wrap && v_wrap) frame_cnt <= frame_cnt + FRAME_W'(1);
            active    <= act_nxt;
            sol       <= (h_nxt == '0);
            sof       <= (h_nxt == '0) && (v_nxt == '0);
            hs_raw    <= hs_nxt;
            vs_raw    <= vs_nxt;
            de_raw    <= act_nxt;
        end
    end

    // de starts low so nothing is shown before the first enabled pixel.
    vga_sync_delay #(
        .DEPTH   (PIPE_DELAY),
        .RST_VAL ({1'b0, ~VSYNC_POL, ~HSYNC_POL})
    ) u_delay (
        .pclk  (pclk),
        .reset (reset),
        .ce    (ce),
        .d     ({de_raw, vs_raw, hs_raw}),
        .q     ({de, vsync, hsync})
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed table-driven bench for vga_timing_gen on a 14x7 raster.
module tb_vga_timing_gen;

    logic pclk = 1'b0;
    logic reset;
    logic ce;

    always #5 pclk = ~pclk;

    logic [10:0] h0, v0, h3, v3, hp, vp;
    logic [7:0]  f0, f3;
    logic [1:0]  fp;
    logic a0, l0, s0, hs0, vs0, d0;
    logic a3, l3, s3, hs3, vs3, d3;
    logic ap, lp, sp, hsp, vsp, dp;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .PIPE_DELAY(0)
    ) u0 (
        .pclk(pclk), .reset(reset), .ce(ce),
        .h_cnt(h0), .v_cnt(v0), .active(a0), .sol(l0), .sof(s0),
        .frame_cnt(f0), .hsync(hs0), .vsync(vs0), .de(d0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .PIPE_DELAY(3)
    ) u3 (
        .pclk(pclk), .reset(reset), .ce(ce),
        .h_cnt(h3), .v_cnt(v3), .active(a3), .sol(l3), .sof(s3),
        .frame_cnt(f3), .hsync(hs3), .vsync(vs3), .de(d3)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .FRAME_W(2), .PIPE_DELAY(0)
    ) up (
        .pclk(pclk), .reset(reset), .ce(ce),
        .h_cnt(hp), .v_cnt(vp), .active(ap), .sol(lp), .sof(sp),
        .frame_cnt(fp), .hsync(hsp), .vsync(vsp), .de(dp)
    );

    typedef struct {
        int k;
        int h;
        int v;
        int fr;
        bit act;
        bit sol;
        bit sof;
        bit hs;
        bit vs;
    } vec_t;

    typedef struct {
        int k;
        bit de;
        bit hs;
    } dvec_t;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    function automatic logic [35:0] pk(input int h, input int v,
                                       input int fr, input bit act,
                                       input bit sol, input bit sof,
                                       input bit hs, input bit vs,
                                       input bit de);
        return {11'(h), 11'(v), 8'(fr), act, sol, sof, hs, vs, de};
    endfunction

    task automatic chk(input string name, input logic [35:0] got,
                       input logic [35:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h", name, k, got, want);
        end
    endtask

    task automatic step(input bit c);
        ce = c;
        @(posedge pclk);
        #1;
        if (c) k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step(1'b1);
    endtask

    function automatic logic [35:0] dut0();
        return {h0, v0, f0, a0, l0, s0, hs0, vs0, d0};
    endfunction

    vec_t  tbl [15];
    dvec_t dtb [10];
    int    sof_seen;

    initial begin
        tbl = '{
            '{  0,  0, 0, 0, 1, 1, 1, 1, 1},
            '{  7,  7, 0, 0, 1, 0, 0, 1, 1},
            '{  8,  8, 0, 0, 0, 0, 0, 1, 1},
            '{ 10, 10, 0, 0, 0, 0, 0, 0, 1},
            '{ 11, 11, 0, 0, 0, 0, 0, 0, 1},
            '{ 12, 12, 0, 0, 0, 0, 0, 1, 1},
            '{ 13, 13, 0, 0, 0, 0, 0, 1, 1},
            '{ 14,  0, 1, 0, 1, 1, 0, 1, 1},
            '{ 39, 11, 2, 0, 0, 0, 0, 0, 1},
            '{ 70,  0, 5, 0, 0, 1, 0, 1, 0},
            '{ 83, 13, 5, 0, 0, 0, 0, 1, 0},
            '{ 84,  0, 6, 0, 0, 1, 0, 1, 1},
            '{ 97, 13, 6, 0, 0, 0, 0, 1, 1},
            '{ 98,  0, 0, 1, 1, 1, 1, 1, 1},
            '{108, 10, 0, 1, 0, 0, 0, 0, 1}
        };
        dtb = '{
            '{ 0, 0, 1}, '{ 1, 0, 1}, '{ 2, 0, 1}, '{ 3, 0, 1},
            '{ 4, 1, 1}, '{12, 0, 1}, '{13, 0, 0}, '{14, 0, 0},
            '{15, 0, 1}, '{17, 1, 1}
        };

        reset = 1'b1;
        ce    = 1'b0;
        #3;
        chk("reset_async", dut0(), pk(0, 0, 0, 1, 1, 1, 1, 1, 0));
        chk("reset_pol", 36'({fp, hsp, vsp, dp}), 36'({2'd0, 1'b0, 1'b0, 1'b0}));
        chk("reset_dly", 36'({hs3, vs3, d3}), 36'({1'b1, 1'b1, 1'b0}));
        @(posedge pclk);
        #1;
        reset = 1'b0;
        k = 0;

        for (int i = 0; i < 15; i++) begin
            run_to(tbl[i].k);
            chk($sformatf("vec%0d", i), dut0(),
                pk(tbl[i].h, tbl[i].v, tbl[i].fr, tbl[i].act,
                   tbl[i].sol, tbl[i].sof, tbl[i].hs, tbl[i].vs,
                   (tbl[i].k == 0) ? 1'b0 : tbl[i].act));
            chk($sformatf("pol%0d", i), 36'({fp, hsp, vsp}),
                36'({2'(tbl[i].fr), ~tbl[i].hs, ~tbl[i].vs}));
        end

        step(1'b1);
        chk("ce_on1", dut0(), pk(11, 0, 1, 0, 0, 0, 0, 1, 0));
        step(1'b0);
        chk("ce_off1", dut0(), pk(11, 0, 1, 0, 0, 0, 0, 1, 0));
        chk("ce_off1_dly", 36'({hs3, d3}), 36'({1'b1, 1'b0}));
        step(1'b1);
        chk("ce_on2", dut0(), pk(12, 0, 1, 0, 0, 0, 1, 1, 0));
        step(1'b0);
        chk("ce_off2", dut0(), pk(12, 0, 1, 0, 0, 0, 1, 1, 0));
        chk("ce_off2_dly", 36'({hs3, d3}), 36'({1'b1, 1'b0}));

        run_to(135);
        chk("pre_reset", dut0(), pk(9, 2, 1, 0, 0, 0, 1, 1, 0));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset", dut0(), pk(0, 0, 0, 1, 1, 1, 1, 1, 0));
        chk("mid_reset_pol", 36'({fp, hsp, vsp}), 36'({2'd0, 1'b0, 1'b0}));
        #1;
        reset = 1'b0;
        k = 0;

        for (int i = 0; i < 10; i++) begin
            run_to(dtb[i].k);
            chk($sformatf("dly%0d", i), 36'({d3, hs3}),
                36'({dtb[i].de, dtb[i].hs}));
            if (i == 1)
                chk("resume", dut0(), pk(1, 0, 0, 1, 0, 0, 1, 1, 1));
        end

        run_to(392);
        chk("frame4", dut0(), pk(0, 0, 4, 1, 1, 1, 1, 1, 1));
        chk("frame_wrap", 36'(fp), 36'(2'd0));

        sof_seen = 0;
        for (int i = 0; i < 98; i++) begin
            step(1'b1);
            if (s0) sof_seen++;
        end
        chk("sof_once", 36'(sof_seen), 36'(1));
        chk("frame5", 36'({f0, fp}), 36'({8'd5, 2'd1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
